cpu_mem_port: RTL

Single-port 16-bit word memory that services the CPU core's two memory clients: instruction fetch (word-addressed, 16-bit) and load/store (byte-addressed, 8-bit). It sits between the CPU core and the storage array. It arbitrates both clients onto one array port with valid/ready handshakes and returns read data through registered responses. Byte addressing follows the core's convention: word = addr>>1; odd address selects bits [15:8], even selects bits [7:0].

---
 rtl/cpu_mem_pkg.sv | 23 ++
 rtl/cpu_mem_port_if.sv | 37 +++
 rtl/mem_arbiter.sv | 44 ++++
 rtl/cpu_mem_port.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU memory port: word/byte types, FSM states,
// and the core's byte-address convention (word = addr>>1, addr[0] selects the high byte).
package cpu_mem_pkg;

  localparam int MEM_WORDS = 32;

  typedef logic [15:0] word_t;
  typedef logic [7:0]  byte_t;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  function automatic logic [6:0] byte_to_word(input byte_t addr);
    return addr[7:1];
  endfunction

  function automatic logic byte_lane(input byte_t addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/cpu_mem_port_if.sv
// Fetch and load/store handshake bundle between the CPU core (master) and cpu_mem_port (slave).
interface cpu_mem_port_if #(
  parameter int ADDR_W = $clog2(cpu_mem_pkg::MEM_WORDS)
);
  import cpu_mem_pkg::*;

  logic              fetch_req_valid;
  logic              fetch_req_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_rsp_valid;
  word_t             fetch_rsp_data;
  logic              fetch_rsp_ready;
  logic              data_req_valid;
  logic              data_req_ready;
  logic              data_req_we;
  byte_t             data_req_addr;
  byte_t             data_req_wdata;
  logic              data_rsp_valid;
  byte_t             data_rsp_data;
  logic              data_rsp_ready;
  logic              busy;

  modport master (
    output fetch_req_valid, fetch_addr, fetch_rsp_ready,
    output data_req_valid, data_req_we, data_req_addr, data_req_wdata, data_rsp_ready,
    input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
    input  data_req_ready, data_rsp_valid, data_rsp_data, busy
  );

  modport slave (
    input  fetch_req_valid, fetch_addr, fetch_rsp_ready,
    input  data_req_valid, data_req_we, data_req_addr, data_req_wdata, data_rsp_ready,
    output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
    output data_req_ready, data_rsp_valid, data_rsp_data, busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-way round-robin grant between the data and fetch clients.
// A contested cycle goes to the client that was not granted last; the pointer starts favouring data.
module mem_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic data_elig,
  input  logic fetch_elig,
  output logic data_gnt,
  output logic fetch_gnt
);

  logic last_fetch_r;

  // Combinational grant selection
  always_comb begin
    data_gnt  = 1'b0;
    fetch_gnt = 1'b0;
    if (en) begin
      if (data_elig && fetch_elig) begin
        data_gnt  = last_fetch_r;
        fetch_gnt = ~last_fetch_r;
      end else begin
        data_gnt  = data_elig;
        fetch_gnt = fetch_elig;
      end
    end else begin
      data_gnt  = 1'b0;
      fetch_gnt = 1'b0;
    end
  end

  // Last-grant pointer, moved only by an actual grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_fetch_r <= 1'b1;
    end else if (data_gnt) begin
      last_fetch_r <= 1'b0;
    end else if (fetch_gnt) begin
      last_fetch_r <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_mem_port.sv
// cpu_mem_port: single-port 16-bit word memory shared by instruction fetch and byte load/store.
// Optional build macro MEM_CLEAR_ON_RESET_EN zeroes the array one word per cycle after reset.
module cpu_mem_port #(
  parameter int MEM_WORDS = cpu_mem_pkg::MEM_WORDS,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input logic           clk,
  input logic           rst,
  cpu_mem_port_if.slave bus
);
  import cpu_mem_pkg::*;

  state_t     state_r;
  state_t     state_s;
  word_t      mem_r [MEM_WORDS];
  logic [6:0] dword_s;
  logic       dlane_s;
  logic       d_in_range_s;
  logic       f_in_range_s;
  word_t      d_word_s;
  word_t      f_word_s;
  byte_t      d_byte_s;
  logic       en_s;
  logic       data_elig_s;
  logic       fetch_elig_s;
  logic       data_gnt_s;
  logic       fetch_gnt_s;
  logic       data_rsp_valid_r;
  byte_t      data_rsp_data_r;
  logic       fetch_rsp_valid_r;
  word_t      fetch_rsp_data_r;

`ifdef MEM_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = ST_CLEAR;
  logic [ADDR_W-1:0] clr_cnt_r;
  assign bus.busy = (state_r == ST_CLEAR);
`else
  localparam state_t RESET_STATE = ST_SERVE;
  assign bus.busy = 1'b0;
`endif

  assign dword_s      = byte_to_word(bus.data_req_addr);
  assign dlane_s      = byte_lane(bus.data_req_addr);
  assign d_in_range_s = (int'(dword_s) < MEM_WORDS);
  assign f_in_range_s = (int'(bus.fetch_addr) < MEM_WORDS);

  // A port holding an unconsumed response cannot issue again
  assign en_s         = (state_r == ST_SERVE) && !rst;
  assign data_elig_s  = bus.data_req_valid && !data_rsp_valid_r;
  assign fetch_elig_s = bus.fetch_req_valid && !fetch_rsp_valid_r;

  mem_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .en         (en_s),
    .data_elig  (data_elig_s),
    .fetch_elig (fetch_elig_s),
    .data_gnt   (data_gnt_s),
    .fetch_gnt  (fetch_gnt_s)
  );

  assign bus.data_req_ready  = data_gnt_s;
  assign bus.fetch_req_ready = fetch_gnt_s;
  assign bus.data_rsp_valid  = data_rsp_valid_r;
  assign bus.data_rsp_data   = data_rsp_data_r;
  assign bus.fetch_rsp_valid = fetch_rsp_valid_r;
  assign bus.fetch_rsp_data  = fetch_rsp_data_r;

  // State register and clear-walk counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= RESET_STATE;
`ifdef MEM_CLEAR_ON_RESET_EN
      clr_cnt_r <= '0;
`endif
    end else begin
      state_r   <= state_s;
`ifdef MEM_CLEAR_ON_RESET_EN
      if (state_r == ST_CLEAR) begin
        clr_cnt_r <= clr_cnt_r + 1'b1;
      end
`endif
    end
  end

  // Next state: CLEAR leaves on the cycle that writes the last word
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CLEAR: begin
`ifdef MEM_CLEAR_ON_RESET_EN
        if (clr_cnt_r == ADDR_W'(MEM_WORDS - 1)) begin
          state_s = ST_SERVE;
        end else begin
          state_s = ST_CLEAR;
        end
`else
        state_s = ST_SERVE;
`endif
      end
      ST_SERVE: state_s = ST_SERVE;
      default:  state_s = ST_SERVE;
    endcase
  end

  // Array read mux; out-of-range addresses read as zero
  always_comb begin
    d_word_s = 16'h0000;
    f_word_s = 16'h0000;
    if (d_in_range_s) begin
      d_word_s = mem_r[dword_s[ADDR_W-1:0]];
    end else begin
      d_word_s = 16'h0000;
    end
    if (f_in_range_s) begin
      f_word_s = mem_r[bus.fetch_addr];
    end else begin
      f_word_s = 16'h0000;
    end
    d_byte_s = dlane_s ? d_word_s[15:8] : d_word_s[7:0];
  end

  // Array write port: clear walk, or a granted in-range store into one byte lane
  always_ff @(posedge clk) begin
`ifdef MEM_CLEAR_ON_RESET_EN
    if (state_r == ST_CLEAR) begin
      mem_r[clr_cnt_r] <= 16'h0000;
    end else
`endif
    if (data_gnt_s && bus.data_req_we && d_in_range_s) begin
      if (dlane_s) begin
        mem_r[dword_s[ADDR_W-1:0]][15:8] <= bus.data_req_wdata;
      end else begin
        mem_r[dword_s[ADDR_W-1:0]][7:0]  <= bus.data_req_wdata;
      end
    end
  end

  // Response registers: captured on a read grant, held stable until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_rsp_valid_r  <= 1'b0;
      data_rsp_data_r   <= 8'h00;
      fetch_rsp_valid_r <= 1'b0;
      fetch_rsp_data_r  <= 16'h0000;
    end else begin
      if (data_gnt_s && !bus.data_req_we) begin
        data_rsp_valid_r <= 1'b1;
        data_rsp_data_r  <= d_byte_s;
      end else if (bus.data_rsp_ready) begin
        data_rsp_valid_r <= 1'b0;
      end
      if (fetch_gnt_s) begin
        fetch_rsp_valid_r <= 1'b1;
        fetch_rsp_data_r  <= f_word_s;
      end else if (bus.fetch_rsp_ready) begin
        fetch_rsp_valid_r <= 1'b0;
      end
    end
  end

endmodule
